// File: rtl/alu_control_pipe_pkg.sv
// Shared ALU opcode encoding, funct7/ALUctrl constants and decode helpers
// for the pipelined ALU-op decoder.
package alu_control_pipe_pkg;

  localparam int ALUOP_WIDTH = 5;

  typedef enum logic [ALUOP_WIDTH-1:0] {
    ADD_OP = 5'd0, SUB_OP, SLL_OP, SLT_OP, SLTU_OP, XOR_OP, SRL_OP, SRA_OP,
    OR_OP, AND_OP, PASS_OP,
    MUL_OP, MULH_OP, MULHSU_OP, MULHU_OP, DIV_OP, DIVU_OP, REM_OP, REMU_OP
  } alu_op_e;

  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [1:0] ALUCTRL_ADD   = 2'b00;
  localparam logic [1:0] ALUCTRL_SUB   = 2'b01;
  localparam logic [1:0] ALUCTRL_FUNCT = 2'b10;
  localparam logic [1:0] ALUCTRL_PASS  = 2'b11;

  // alt selects arithmetic right shift for funct3=101
  function automatic alu_op_e base_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return ADD_OP;
      3'b001:  return SLL_OP;
      3'b010:  return SLT_OP;
      3'b011:  return SLTU_OP;
      3'b100:  return XOR_OP;
      3'b101:  return alt ? SRA_OP : SRL_OP;
      3'b110:  return OR_OP;
      default: return AND_OP;
    endcase
  endfunction

  function automatic alu_op_e muldiv_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return MUL_OP;
      3'b001:  return MULH_OP;
      3'b010:  return MULHSU_OP;
      3'b011:  return MULHU_OP;
      3'b100:  return DIV_OP;
      3'b101:  return DIVU_OP;
      3'b110:  return REM_OP;
      default: return REMU_OP;
    endcase
  endfunction

endpackage

// File: rtl/alu_control_pipe_if.sv
// Decode-request / decoded-result bundle between control unit and ALU pipe.
interface alu_control_pipe_if
  import alu_control_pipe_pkg::*;
#(
  parameter int TID_W     = 4,
  parameter int CNT_WIDTH = 16
);
  logic                   i_valid;
  logic                   i_stall;
  logic [TID_W-1:0]       i_tid;
  logic [1:0]             i_ALUctrl;
  logic [2:0]             i_funct3;
  logic [6:0]             i_funct7;
  logic                   i_rtype;
  logic                   i_flush_valid;
  logic [TID_W-1:0]       i_flush_tid;
  logic                   o_valid;
  logic [TID_W-1:0]       o_tid;
  logic [ALUOP_WIDTH-1:0] o_ALUOp;
  logic                   o_illegal;
  logic [CNT_WIDTH-1:0]   o_illegal_count;

  modport master (
    output i_valid, i_stall, i_tid, i_ALUctrl, i_funct3, i_funct7, i_rtype,
           i_flush_valid, i_flush_tid,
    input  o_valid, o_tid, o_ALUOp, o_illegal, o_illegal_count
  );

  modport slave (
    input  i_valid, i_stall, i_tid, i_ALUctrl, i_funct3, i_funct7, i_rtype,
           i_flush_valid, i_flush_tid,
    output o_valid, o_tid, o_ALUOp, o_illegal, o_illegal_count
  );
endinterface

// File: rtl/alu_control_pipe_decode.sv
// Combinational ALU-op decoder: {ALUctrl, funct3, funct7, rtype} -> op + illegal.
module alu_op_decode
  import alu_control_pipe_pkg::*;
#(
  parameter bit ENABLE_M      = 1'b0,
  parameter bit STRICT_DECODE = 1'b1
) (
  input  logic [1:0] alu_ctrl_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  input  logic       rtype_i,
  output alu_op_e    alu_op_o,
  output logic       illegal_o
);
  alu_op_e op;
  logic    ill;

  always_comb begin
    op  = ADD_OP;
    ill = 1'b0;
    case (alu_ctrl_i)
      ALUCTRL_ADD:  op = ADD_OP;
      ALUCTRL_SUB:  op = SUB_OP;
      ALUCTRL_PASS: op = PASS_OP;
      default: begin
        if (!rtype_i) begin
          // immediate forms: funct7 only matters for the shift encodings
          op = base_op(funct3_i, funct7_i[5]);
          if (STRICT_DECODE && (funct3_i == 3'b001 || funct3_i == 3'b101) &&
              funct7_i != FUNCT7_BASE && funct7_i != FUNCT7_ALT)
            ill = 1'b1;
        end else begin
          case (funct7_i)
            FUNCT7_BASE: op = base_op(funct3_i, 1'b0);
            FUNCT7_ALT: begin
              if (funct3_i == 3'b000)      op = SUB_OP;
              else if (funct3_i == 3'b101) op = SRA_OP;
              else if (STRICT_DECODE)      ill = 1'b1;
              else                         op = base_op(funct3_i, 1'b0);
            end
            FUNCT7_MULDIV: begin
              if (ENABLE_M) op = muldiv_op(funct3_i);
              else          ill = 1'b1;
            end
            default: begin
              if (STRICT_DECODE) ill = 1'b1;
              else               op = base_op(funct3_i, 1'b0);
            end
          endcase
        end
      end
    endcase
    alu_op_o  = ill ? ADD_OP : op;
    illegal_o = ill;
  end
endmodule

// File: rtl/alu_control_pipe.sv
// Decoded ALU-op pipeline with stall, per-hart flush and saturating illegal-op counter.
module alu_control_pipe
  import alu_control_pipe_pkg::*;
#(
  parameter int LATENCY       = 1,
  parameter int NUM_THREADS   = 16,
  parameter bit ENABLE_M      = 1'b0,
  parameter bit STRICT_DECODE = 1'b1,
  parameter int CNT_WIDTH     = 16
) (
  input logic clk,
  input logic reset,
  alu_control_pipe_if.slave bus
);
  localparam int TID_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

  alu_op_e dec_op;
  logic    dec_ill;

  alu_op_decode #(.ENABLE_M(ENABLE_M), .STRICT_DECODE(STRICT_DECODE)) u_dec (
    .alu_ctrl_i (bus.i_ALUctrl),
    .funct3_i   (bus.i_funct3),
    .funct7_i   (bus.i_funct7),
    .rtype_i    (bus.i_rtype),
    .alu_op_o   (dec_op),
    .illegal_o  (dec_ill)
  );

  logic [LATENCY:1]                  vld_q, vld_d, src_vld;
  logic [LATENCY:1][TID_W-1:0]       tid_q, tid_d, src_tid;
  logic [LATENCY:1][ALUOP_WIDTH-1:0] op_q, op_d, src_op;
  logic [LATENCY:1]                  ill_q, ill_d, src_ill;
  logic [CNT_WIDTH-1:0]              cnt_q, cnt_d;

  logic             fv;
  logic [TID_W-1:0] ftid;
  assign fv   = bus.i_flush_valid;
  assign ftid = bus.i_flush_tid;

  // what each stage would load on an unstalled edge
  always_comb begin
    src_vld    = '0;
    src_tid    = '0;
    src_op     = '0;
    src_ill    = '0;
    src_vld[1] = bus.i_valid;
    src_tid[1] = bus.i_tid;
    src_op[1]  = dec_op;
    src_ill[1] = dec_ill;
    for (int k = 2; k <= LATENCY; k++) begin
      src_vld[k] = vld_q[k-1];
      src_tid[k] = tid_q[k-1];
      src_op[k]  = op_q[k-1];
      src_ill[k] = ill_q[k-1];
    end
  end

  // anything not kept (bubble or flushed) collapses to an all-zero entry
  always_comb begin
    vld_d = '0;
    tid_d = '0;
    op_d  = '0;
    ill_d = '0;
    for (int k = 1; k <= LATENCY; k++) begin
      if (bus.i_stall) begin
        if (vld_q[k] && !(fv && tid_q[k] == ftid)) begin
          vld_d[k] = 1'b1;
          tid_d[k] = tid_q[k];
          op_d[k]  = op_q[k];
          ill_d[k] = ill_q[k];
        end
      end else if (src_vld[k] && !(fv && src_tid[k] == ftid)) begin
        vld_d[k] = 1'b1;
        tid_d[k] = src_tid[k];
        op_d[k]  = src_op[k];
        ill_d[k] = src_ill[k];
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (vld_q[LATENCY] && ill_q[LATENCY] && !bus.i_stall &&
        !(fv && tid_q[LATENCY] == ftid) && cnt_q != '1)
      cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      tid_q <= '0;
      op_q  <= '0;
      ill_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      tid_q <= tid_d;
      op_q  <= op_d;
      ill_q <= ill_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.o_valid         = vld_q[LATENCY];
  assign bus.o_tid           = tid_q[LATENCY];
  assign bus.o_ALUOp         = op_q[LATENCY];
  assign bus.o_illegal       = ill_q[LATENCY];
  assign bus.o_illegal_count = cnt_q;
endmodule

// File: tb/tb_alu_control_pipe.sv
// Two configurations driven in lockstep: A = LATENCY 2, strict, no M, 2-bit counter;
// B = LATENCY 3, lenient, RV32M, 16-bit counter. Scoreboard per DUT plus directed tasks.
module tb_alu_control_pipe;
  import alu_control_pipe_pkg::*;

  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  logic       v = 0, stall = 0, rt = 0, fv = 0;
  logic [3:0] tid = 0, ftid = 0;
  logic [1:0] ctrl = 0;
  logic [2:0] f3 = 0;
  logic [6:0] f7 = 0;
  int checks = 0, errors = 0;

  alu_control_pipe_if #(.TID_W(4), .CNT_WIDTH(2))  ifa ();
  alu_control_pipe_if #(.TID_W(4), .CNT_WIDTH(16)) ifb ();

  assign ifa.i_valid = v;   assign ifb.i_valid = v;
  assign ifa.i_stall = stall; assign ifb.i_stall = stall;
  assign ifa.i_tid = tid;   assign ifb.i_tid = tid;
  assign ifa.i_ALUctrl = ctrl; assign ifb.i_ALUctrl = ctrl;
  assign ifa.i_funct3 = f3; assign ifb.i_funct3 = f3;
  assign ifa.i_funct7 = f7; assign ifb.i_funct7 = f7;
  assign ifa.i_rtype = rt;  assign ifb.i_rtype = rt;
  assign ifa.i_flush_valid = fv; assign ifb.i_flush_valid = fv;
  assign ifa.i_flush_tid = ftid; assign ifb.i_flush_tid = ftid;

  alu_control_pipe #(.LATENCY(2), .NUM_THREADS(16), .ENABLE_M(0), .STRICT_DECODE(1),
                     .CNT_WIDTH(2)) u_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  alu_control_pipe #(.LATENCY(3), .NUM_THREADS(16), .ENABLE_M(1), .STRICT_DECODE(0),
                     .CNT_WIDTH(16)) u_b (.clk(clk), .reset(reset), .bus(ifb.slave));

  logic        ov[2], oill[2];
  logic [3:0]  otid[2];
  logic [4:0]  oop[2];
  logic [15:0] ocnt[2];
  assign ov[0] = ifa.o_valid;   assign ov[1] = ifb.o_valid;
  assign oill[0] = ifa.o_illegal; assign oill[1] = ifb.o_illegal;
  assign otid[0] = ifa.o_tid;   assign otid[1] = ifb.o_tid;
  assign oop[0] = ifa.o_ALUOp;  assign oop[1] = ifb.o_ALUOp;
  assign ocnt[0] = {14'd0, ifa.o_illegal_count};
  assign ocnt[1] = ifb.o_illegal_count;

  typedef struct packed { logic [3:0] tid; logic [4:0] op; logic ill; } exp_t;
  exp_t qa[$], qb[$], mq[$], mkeep[$];
  exp_t me;
  int   exp_cnt[2];

  function automatic exp_t model(input bit em, input bit st, input logic [3:0] t,
                                 input logic [1:0] c, input logic [2:0] fn3,
                                 input logic [6:0] fn7, input logic r);
    exp_t e;
    logic [4:0] b;
    case (fn3)
      3'd0: b = ADD_OP;  3'd1: b = SLL_OP; 3'd2: b = SLT_OP; 3'd3: b = SLTU_OP;
      3'd4: b = XOR_OP;  3'd5: b = fn7[5] ? SRA_OP : SRL_OP;
      3'd6: b = OR_OP;   default: b = AND_OP;
    endcase
    e.tid = t; e.op = ADD_OP; e.ill = 1'b0;
    case (c)
      2'b00: e.op = ADD_OP;
      2'b01: e.op = SUB_OP;
      2'b11: e.op = PASS_OP;
      default: begin
        if (!r) begin
          e.op = b;
          if (st && (fn3 == 3'd1 || fn3 == 3'd5) && fn7 != 7'h00 && fn7 != 7'h20) e.ill = 1'b1;
        end else if (fn7 == 7'h00) e.op = b;
        else if (fn7 == 7'h20) begin
          if (fn3 == 3'd0) e.op = SUB_OP;
          else if (fn3 == 3'd5) e.op = SRA_OP;
          else if (st) e.ill = 1'b1;
          else e.op = b;
        end else if (fn7 == 7'h01) begin
          if (!em) e.ill = 1'b1;
          else case (fn3)
            3'd0: e.op = MUL_OP;  3'd1: e.op = MULH_OP; 3'd2: e.op = MULHSU_OP;
            3'd3: e.op = MULHU_OP; 3'd4: e.op = DIV_OP; 3'd5: e.op = DIVU_OP;
            3'd6: e.op = REM_OP;  default: e.op = REMU_OP;
          endcase
        end else if (st) e.ill = 1'b1;
        else e.op = (fn3 == 3'd5) ? SRL_OP : b;
      end
    endcase
    if (e.ill) e.op = ADD_OP;
    return e;
  endfunction

  // scoreboard: inputs/outputs are stable here; bookkeeping describes the next posedge
  always @(negedge clk) begin
    if (reset) begin
      qa.delete(); qb.delete();
      exp_cnt[0] = 0; exp_cnt[1] = 0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (d == 0) mq = qa; else mq = qb;
        checks++;
        if (ocnt[d] !== 16'(exp_cnt[d])) begin
          errors++;
          $display("FAIL sb_count dut%0d got %0d exp %0d", d, ocnt[d], exp_cnt[d]);
        end
        if (ov[d] && !stall) begin
          checks++;
          if (mq.size() == 0) begin
            errors++;
            $display("FAIL sb_extra dut%0d got tid %0d op %0d, none expected", d, otid[d], oop[d]);
          end else begin
            me = mq.pop_front();
            if ({otid[d], oop[d], oill[d]} !== {me.tid, me.op, me.ill}) begin
              errors++;
              $display("FAIL sb_entry dut%0d got tid %0d op %0d ill %0d exp tid %0d op %0d ill %0d",
                       d, otid[d], oop[d], oill[d], me.tid, me.op, me.ill);
            end
            if (me.ill && !(fv && ftid == me.tid) && exp_cnt[d] < ((d == 0) ? 3 : 65535))
              exp_cnt[d]++;
          end
        end else if (!ov[d]) begin
          checks++;
          if ({otid[d], oop[d], oill[d]} !== 10'd0) begin
            errors++;
            $display("FAIL sb_bubble dut%0d got tid %0d op %0d ill %0d exp 0", d, otid[d], oop[d], oill[d]);
          end
        end
        if (fv) begin
          mkeep.delete();
          foreach (mq[i]) if (mq[i].tid != ftid) mkeep.push_back(mq[i]);
          mq = mkeep;
        end
        if (v && !stall && !(fv && tid == ftid))
          mq.push_back(model(d == 1, d == 0, tid, ctrl, f3, f7, rt));
        if (d == 0) qa = mq; else qb = mq;
      end
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic req(input logic [3:0] t, input logic [1:0] c, input logic [2:0] fn3,
                     input logic [6:0] fn7, input logic r);
    v = 1; tid = t; ctrl = c; f3 = fn3; f7 = fn7; rt = r;
  endtask
  task automatic idle(); v = 0; tid = 0; ctrl = 0; f3 = 0; f7 = 0; rt = 0; endtask

  task automatic expect_out(input int d, input string nm, input logic [3:0] t,
                            input logic [4:0] op, input logic il);
    checks++;
    if ({ov[d], otid[d], oop[d], oill[d]} !== {1'b1, t, op, il}) begin
      errors++;
      $display("FAIL %s dut%0d got v%0d tid %0d op %0d ill %0d exp v1 tid %0d op %0d ill %0d",
               nm, d, ov[d], otid[d], oop[d], oill[d], t, op, il);
    end
  endtask

  task automatic expect_all_zero(input string nm);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({ov[d], otid[d], oop[d], oill[d], ocnt[d]} !== 27'd0) begin
        errors++;
        $display("FAIL %s dut%0d got v%0d tid %0d op %0d ill %0d cnt %0d exp all 0",
                 nm, d, ov[d], otid[d], oop[d], oill[d], ocnt[d]);
      end
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    expect_all_zero("reset_state");
    reset = 0;
  endtask

  task automatic test_latency();
    req(4'd3, 2'b10, 3'b101, 7'b0100000, 1'b1);
    tick(); idle();
    checks++;
    if (ov[0] !== 1'b0 || ov[1] !== 1'b0) begin
      errors++; $display("FAIL lat_early got a=%0d b=%0d exp 0 0", ov[0], ov[1]);
    end
    tick();
    expect_out(0, "lat_a_sra", 4'd3, 5'(SRA_OP), 1'b0);
    checks++;
    if (ov[1] !== 1'b0) begin errors++; $display("FAIL lat_b_early got %0d exp 0", ov[1]); end
    tick();
    expect_out(1, "lat_b_sra", 4'd3, 5'(SRA_OP), 1'b0);
    checks++;
    if (ov[0] !== 1'b0) begin errors++; $display("FAIL lat_a_late got %0d exp 0", ov[0]); end
  endtask

  task automatic test_muldiv();
    req(4'd5, 2'b10, 3'b000, 7'b0000001, 1'b1);
    tick(); idle();
    tick();
    expect_out(0, "m_illegal_a", 4'd5, 5'(ADD_OP), 1'b1);
    tick();
    checks++;
    if (ocnt[0] !== 16'd1) begin errors++; $display("FAIL m_cnt_a got %0d exp 1", ocnt[0]); end
    expect_out(1, "m_mul_b", 4'd5, 5'(MUL_OP), 1'b0);
    tick();
    checks++;
    if (ocnt[1] !== 16'd0) begin errors++; $display("FAIL m_cnt_b got %0d exp 0", ocnt[1]); end
  endtask

  task automatic test_flush();
    int n1 = 0, n2 = 0;
    req(4'd1, 2'b01, 3'b100, 7'b0000000, 1'b0); tick();
    req(4'd2, 2'b10, 3'b110, 7'b0000000, 1'b1); tick();
    req(4'd1, 2'b10, 3'b111, 7'b0000000, 1'b1); tick();
    idle(); fv = 1; ftid = 4'd1;
    tick();
    fv = 0; ftid = 0;
    checks++;
    if (ov[0] !== 1'b0) begin errors++; $display("FAIL flush_a got valid %0d exp 0", ov[0]); end
    for (int i = 0; i < 4; i++) begin
      if (ov[1] && otid[1] == 4'd1) n1++;
      if (ov[1] && otid[1] == 4'd2) n2++;
      tick();
    end
    checks++;
    if (n1 != 0 || n2 != 1) begin
      errors++; $display("FAIL flush_b got tid1 x%0d tid2 x%0d exp 0 and 1", n1, n2);
    end
  endtask

  task automatic test_stall();
    req(4'd4, 2'b10, 3'b000, 7'b0000001, 1'b1); tick();
    req(4'd6, 2'b10, 3'b101, 7'b0000000, 1'b0); tick();
    req(4'd7, 2'b10, 3'b001, 7'b0000011, 1'b0); tick();
    req(4'd8, 2'b01, 3'b000, 7'b0000000, 1'b0);
    stall = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_out(0, "stall_a", 4'd6, 5'(SRL_OP), 1'b0);
      expect_out(1, "stall_b", 4'd4, 5'(MUL_OP), 1'b0);
      checks++;
      if (ocnt[0] !== 16'd2 || ocnt[1] !== 16'd0) begin
        errors++; $display("FAIL stall_cnt got a=%0d b=%0d exp 2 0", ocnt[0], ocnt[1]);
      end
    end
    stall = 0; idle();
    repeat (5) tick();
    checks++;
    if (qa.size() != 0 || qb.size() != 0 || ocnt[0] !== 16'd3) begin
      errors++;
      $display("FAIL stall_drain got pending a=%0d b=%0d cnt_a %0d exp 0 0 3", qa.size(), qb.size(), ocnt[0]);
    end
  endtask

  task automatic test_reset_mid();
    req(4'd9,  2'b10, 3'b010, 7'b0100000, 1'b1); tick();
    req(4'd10, 2'b10, 3'b101, 7'b0100000, 1'b0); tick();
    req(4'd11, 2'b10, 3'b011, 7'b1111111, 1'b1); tick();
    idle();
    #2 reset = 1;
    #1 expect_all_zero("reset_mid");
    tick();
    reset = 0;
    req(4'd12, 2'b11, 3'b000, 7'b0000000, 1'b0);
    tick(); idle();
    checks++;
    if (ov[0] !== 1'b0) begin errors++; $display("FAIL post_reset_early got %0d exp 0", ov[0]); end
    tick();
    expect_out(0, "post_reset_a", 4'd12, 5'(PASS_OP), 1'b0);
    tick();
    expect_out(1, "post_reset_b", 4'd12, 5'(PASS_OP), 1'b0);
  endtask

  task automatic test_saturate();
    int e;
    for (int k = 0; k < 7; k++) begin
      if (k < 5) req(4'(k + 1), 2'b10, 3'(k), 7'b0000001, 1'b1);
      else idle();
      tick();
      e = (k < 2) ? 0 : ((k - 1 > 3) ? 3 : k - 1);
      checks++;
      if (ocnt[0] !== 16'(e)) begin
        errors++; $display("FAIL saturate step %0d got %0d exp %0d", k, ocnt[0], e);
      end
    end
    idle();
    repeat (4) tick();
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++; $display("FAIL final_drain got pending a=%0d b=%0d exp 0 0", qa.size(), qb.size());
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_muldiv();
    test_flush();
    test_stall();
    test_reset_mid();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_control_pipe.md
Name: alu_control_pipe

Overview:
Parametrised, pipelined successor to the single-stage ALU-op decoder. It maps {ALUctrl, funct3, funct7, rtype} to an ALU opcode, with optional RV32M decode and an illegal-encoding flag. Results pass through a configurable-depth valid/stall/flush pipeline tagged with hart ID, for the barrel-threaded core. It sits between the main control unit and the ALU/MDU in the decode→execute path.

Parameters:
LATENCY, 1, number of register stages from input to output (1..4)
NUM_THREADS, 16, harts in barrel; tag width TID_W = $clog2(NUM_THREADS), minimum 1
ENABLE_M, 0, 1 = decode funct7=0000001 as RV32M ops; 0 = such encodings illegal when i_rtype=1
STRICT_DECODE, 1, 1 = R-type funct7 other than legal values flags illegal
CNT_WIDTH, 16, width of saturating illegal-op counter

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
i_valid  in  1  input decode request valid
i_stall  in  1  freeze entire pipeline
i_tid  in  TID_W  hart ID of request
i_ALUctrl  in  2  control-unit ALU class
i_funct3  in  3  instruction funct3
i_funct7  in  7  instruction funct7
i_rtype  in  1  1 = register-register op (funct7 significant for ADD/SUB)
i_flush_valid  in  1  kill in-flight entries of one hart
i_flush_tid  in  TID_W  hart to flush
o_valid  out  1  output entry valid
o_tid  out  TID_W  hart ID of output entry
o_ALUOp  out  ALUOP_WIDTH  decoded ALU op
o_illegal  out  1  encoding illegal; o_ALUOp forced to ADD_OP
o_illegal_count  out  CNT_WIDTH  saturating count of illegal entries retired

Behaviour:
- Reset (async assert, sync release at clk edge): all stage valids 0, payloads (tid, ALUOp, illegal) 0, counter 0; all outputs 0.
- Decode (combinational, ahead of stage 1):
  - ALUctrl 00→ADD_OP; 01→SUB_OP; 11→PASS_OP.
  - ALUctrl 10, funct7=0000000 or i_rtype=0: funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND; 101 SRL if funct7[5]=0 else SRA.
  - ALUctrl 10, i_rtype=1, funct7=0100000: funct3 000→SUB_OP, 101→SRA_OP, others illegal if STRICT_DECODE else base op.
  - ALUctrl 10, i_rtype=1, funct7=0000001: ENABLE_M=1 → funct3 000..111 = MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU; ENABLE_M=0 → illegal.
  - Any other R-type funct7: illegal if STRICT_DECODE, else decode as funct7=0000000.
  - i_rtype=0 shift-immediate (funct3 001/101): funct7 other than 0000000/0100000 → illegal if STRICT_DECODE.
  - Illegal → ALUOp=ADD_OP, illegal=1.
- Pipeline: LATENCY stages; stage k loads stage k-1 (stage 0 = decode of inputs).
  - i_stall=1: every stage holds; input ignored (upstream holds request). Counter holds.
  - i_stall=0: shift one stage; stage 1 valid <= i_valid.
  - Bubble (valid=0) forces payload to 0 on load.
  - Latency: request at edge n with no stall appears at o_* after edge n+LATENCY-1 (visible in cycle n+LATENCY-1 following edge), i.e. LATENCY edges including capture.
- Flush: i_flush_valid=1 clears valid (and zeroes payload) of every stage whose tid == i_flush_tid, including the entry being captured this edge. Flush acts even when i_stall=1 (non-matching stages hold). Flush wins over stall for matching entries.
- Counter: increments by 1 at an edge where o_valid=1, o_illegal=1, i_stall=0, and the output entry is not flushed that edge; saturates at 2^CNT_WIDTH-1 (no wrap).
- Reset mid-operation clears all in-flight entries immediately; no partial outputs.

Decomposition:
- riscv_pkg additions: MUL_OP, MULH_OP, MULHSU_OP, MULHU_OP, DIV_OP, DIVU_OP, REM_OP, REMU_OP; ALUOP_WIDTH widened to hold all ops (≥5); FUNCT7_BASE=7'b0000000, FUNCT7_ALT=7'b0100000, FUNCT7_MULDIV=7'b0000001; ALUCTRL_* class constants.
- Sub-module alu_op_decode: purely combinational decoder (ALUctrl/funct3/funct7/rtype → ALUOp, illegal), parameterised by ENABLE_M and STRICT_DECODE. The top level holds pipeline, flush and counter logic.

Test Plan:
- LATENCY=2, request ALUctrl=10, funct3=101, funct7=0100000, rtype=1, tid=3 → o_valid=1, o_ALUOp=SRA_OP, o_tid=3 exactly 2 edges later; o_illegal=0.
- ENABLE_M=0, rtype=1, funct7=0000001, funct3=000 → o_illegal=1, o_ALUOp=ADD_OP, counter 0→1; with ENABLE_M=1 the same input gives MUL_OP, counter unchanged.
- LATENCY=3, back-to-back tids 1,2,1; i_flush_valid with tid=1 while entries are in stages 1–3 → only tid 2 emerges; no tid-1 output.
- i_stall held 4 cycles with full pipeline → outputs frozen, counter frozen; after release, entries drain in order with no loss or duplication.
- CNT_WIDTH=2, 5 consecutive illegal requests → counter 1,2,3,3,3 (saturates).
- Async reset asserted mid-stream between edges → o_valid, o_ALUOp, o_tid and counter all 0 immediately; first post-reset request has normal latency.
